// File: rtl/ball_pkg.sv
// ---------------------------------------------------------------------------
// ball_pkg
// Shared definitions for the ball serializer slice.
//   BALL_FRAME_W / BALL_DEPTH : default frame width (balls) and FIFO depth
//   BALL_RED / BALL_BLUE      : colour encoding of one ball bit
//   ball_state_t, ST_IDLE/ST_SHIFT : shifter FSM state type and encodings
//   ball_colour()             : maps a raw frame bit onto the colour encoding
// ---------------------------------------------------------------------------
package ball_pkg;

    localparam int BALL_FRAME_W = 8;
    localparam int BALL_DEPTH   = 4;

    localparam logic BALL_RED  = 1'b1;
    localparam logic BALL_BLUE = 1'b0;

    typedef logic [0:0] ball_state_t;
    localparam ball_state_t ST_IDLE  = 1'b0;  // no frame loaded
    localparam ball_state_t ST_SHIFT = 1'b1;  // frame loaded, bits being issued

    function automatic logic ball_colour(input logic b);
        return b ? BALL_RED : BALL_BLUE;
    endfunction

endpackage

// File: rtl/ball_fifo.sv
// ---------------------------------------------------------------------------
// ball_fifo
// Synchronous frame FIFO with occupancy count; head is shown combinationally.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_push, i_data  : write request and frame (ignored when full)
//   i_pop           : read request (ignored when empty)
//   o_head          : frame at the read pointer
//   o_count         : frames stored
//   o_full, o_empty : occupancy flags derived from o_count
// ---------------------------------------------------------------------------
module ball_fifo
    import ball_pkg::*;
#(
    parameter int W     = BALL_FRAME_W,
    parameter int DEPTH = BALL_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ball_serializer.sv
// ---------------------------------------------------------------------------
// ball_serializer
// Queues ball frames and shifts them out MSB first, one ball per unpaused
// cycle, with back-to-back frames issued without a gap.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   in_data/in_valid/in_ready : frame input; a frame is taken on any edge
//                            with in_valid=1 and in_ready=1 (in_ready does
//                            not depend on in_valid)
//   pause                  : downstream hold, no ball issued while high
//   di, di_valid           : registered serial ball bit and its qualifier
//   frame_done             : pulses with the last ball of each frame
//   fifo_count             : frames waiting (not counting the one shifting)
//   dbg_state              : current shifter state
// ---------------------------------------------------------------------------
module ball_serializer
    import ball_pkg::*;
#(
    parameter int FRAME_W = BALL_FRAME_W,
    parameter int DEPTH   = BALL_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FRAME_W-1:0]     in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   pause,
    output logic                   di,
    output logic                   di_valid,
    output logic                   frame_done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output ball_state_t            dbg_state
);

    localparam int LW = $clog2(FRAME_W + 1);

    ball_state_t          r_state;
    logic [FRAME_W-1:0]   r_shreg;   // remaining bits, next one at the MSB
    logic [LW-1:0]        r_left;    // bits still to issue from r_shreg
    logic                 r_di;
    logic                 r_di_valid;
    logic                 r_frame_done;

    logic [FRAME_W-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drained;
    logic                 w_pop;
    logic                 w_push;

    // After the last bit of a frame the FSM may stay in SHIFT with nothing
    // left when another frame is waiting; both cases load from the FIFO.
    assign w_drained = (r_state == ST_IDLE) || (r_left == '0);
    assign w_pop     = !pause && w_drained && !w_empty;
    assign in_ready  = !w_full && !rst;
    assign w_push    = in_valid && in_ready;

    ball_fifo #(
        .W     (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_left       <= '0;
            r_di         <= BALL_BLUE;
            r_di_valid   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_di         <= BALL_BLUE;
            r_di_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            if (!pause) begin
                if (!w_drained) begin
                    r_di       <= ball_colour(r_shreg[FRAME_W-1]);
                    r_di_valid <= 1'b1;
                    r_shreg    <= r_shreg << 1;
                    r_left     <= r_left - LW'(1);
                    if (r_left == LW'(1)) begin
                        r_frame_done <= 1'b1;
                        r_state      <= w_empty ? ST_IDLE : ST_SHIFT;
                    end
                end else if (!w_empty) begin
                    // Pop and issue the new frame's first ball on the same edge.
                    r_di       <= ball_colour(w_head[FRAME_W-1]);
                    r_di_valid <= 1'b1;
                    r_shreg    <= w_head << 1;
                    r_left     <= LW'(FRAME_W - 1);
                    r_state    <= ST_SHIFT;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    assign di         = r_di;
    assign di_valid   = r_di_valid;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ball_serializer.sv
module tb_ball_serializer;
    import ball_pkg::*;

    localparam int FW = 8;
    localparam int DP = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        pause = 1'b0;
    logic        in_ready;
    logic        di;
    logic        di_valid;
    logic        frame_done;
    logic [2:0]  fifo_count;
    ball_state_t dbg_state;

    always #5 clk = ~clk;

    ball_serializer #(.FRAME_W(FW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pause      (pause),
        .di         (di),
        .di_valid   (di_valid),
        .frame_done (frame_done),
        .fifo_count (fifo_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fq[$];      // frames waiting
    logic       bq[$];      // balls left of the frame being shifted
    logic [0:0] exp_q[$];   // every accepted ball, in emission order

    logic e_di, e_dv, e_fd, e_rdy;
    int   e_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        bq.delete();
        exp_q.delete();
    endtask

    // One clock edge of behaviour, computed from the inputs ahead of it.
    task automatic model_step(input logic v, input logic [7:0] d, input logic p);
        logic       acc;
        logic [7:0] f;
        acc  = v && (fq.size() < DP);
        e_di = 1'b0;
        e_dv = 1'b0;
        e_fd = 1'b0;
        if (!p) begin
            if (bq.size() == 0 && fq.size() > 0) begin
                f = fq.pop_front();
                for (int i = FW - 1; i >= 0; i--) bq.push_back(f[i]);
            end
            if (bq.size() > 0) begin
                e_di = bq.pop_front();
                e_dv = 1'b1;
                e_fd = (bq.size() == 0);
            end
        end
        if (acc) begin
            fq.push_back(d);
            for (int i = FW - 1; i >= 0; i--) exp_q.push_back(d[i]);
        end
        e_cnt = fq.size();
        e_rdy = (fq.size() < DP);
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic p);
        logic [0:0] b;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        pause    = p;
        model_step(v, d, p);
        @(posedge clk);
        #1;
        check("di",         32'(di),         32'(e_di));
        check("di_valid",   32'(di_valid),   32'(e_dv));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("fifo_count", 32'(fifo_count), 32'(e_cnt));
        check("in_ready",   32'(in_ready),   32'(e_rdy));
        if (di_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_bit: got di=%0b expected no ball at %0t", di, $time);
            end else begin
                b = exp_q.pop_front();
                check("sb_order", 32'(di), 32'(b));
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       p;
        logic       x_di;
        logic       x_dv;
        logic       x_fd;
        int         x_cnt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic a_bits [8];
        logic c_first [3];
        logic c_rest [5];
        int   dv_cnt, first_dv, last_dv, stale;
        int   fd_cyc[$];

        a_bits  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        c_first = '{1'b1, 1'b1, 1'b0};
        c_rest  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        tbl[0] = '{1'b1, 8'b1010_1100, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b0, 8'h00, 1'b0, a_bits[i-1], 1'b1, (i == 8), 0};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_di",         32'(di),         32'd0);
        check("rst_di_valid",   32'(di_valid),   32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_state",      32'(dbg_state),  32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        model_reset();

        // Single frame, table driven
        for (int i = 0; i < 10; i++) begin
            drive_cycle(tbl[i].v, tbl[i].d, tbl[i].p);
            check("tbl_di",         32'(di),         32'(tbl[i].x_di));
            check("tbl_di_valid",   32'(di_valid),   32'(tbl[i].x_dv));
            check("tbl_frame_done", 32'(frame_done), 32'(tbl[i].x_fd));
            check("tbl_fifo_count", 32'(fifo_count), 32'(tbl[i].x_cnt));
        end

        // Back-to-back FF then 00
        dv_cnt = 0; first_dv = -1; last_dv = -1;
        for (int c = 0; c < 20; c++) begin
            drive_cycle(c < 2, (c == 0) ? 8'hFF : 8'h00, 1'b0);
            if (di_valid) begin
                dv_cnt++;
                if (first_dv < 0) first_dv = c;
                last_dv = c;
                check("b2b_value", 32'(di), (dv_cnt <= 8) ? 32'd1 : 32'd0);
            end
            if (frame_done) fd_cyc.push_back(c);
        end
        check("b2b_valid_cycles", 32'(dv_cnt), 32'd16);
        check("b2b_contiguous",   32'(last_dv - first_dv + 1), 32'd16);
        check("b2b_done_count",   32'(fd_cyc.size()), 32'd2);
        if (fd_cyc.size() == 2)
            check("b2b_done_spacing", 32'(fd_cyc[1] - fd_cyc[0]), 32'd8);

        // Fill while paused, then release
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            if (c == 3) begin
                check("fill_count",    32'(fifo_count), 32'd4);
                check("fill_in_ready", 32'(in_ready),   32'd0);
                check("fill_di_valid", 32'(di_valid),   32'd0);
            end
        end
        drive_cycle(1'b0, 8'h00, 1'b0);
        check("release_in_ready", 32'(in_ready),   32'd1);
        check("release_count",    32'(fifo_count), 32'd3);
        for (int c = 0; c < 34; c++) drive_cycle(1'b0, 8'h00, 1'b0);

        // Pause after third ball of 1100_1010
        drive_cycle(1'b1, 8'b1100_1010, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, 8'h00, 1'b0);
            check("pz_first_bits", 32'(di), 32'(c_first[c]));
        end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, 8'h00, 1'b1);
            check("pz_held", 32'(di_valid), 32'd0);
        end
        for (int c = 0; c < 5; c++) begin
            drive_cycle(1'b0, 8'h00, 1'b0);
            check("pz_resume_valid", 32'(di_valid), 32'd1);
            check("pz_resume_bits",  32'(di),       32'(c_rest[c]));
        end
        repeat (2) drive_cycle(1'b0, 8'h00, 1'b0);

        // Push at count 3 on the same edge as a pop
        drive_cycle(1'b1, 8'h3C, 1'b0);
        drive_cycle(1'b1, 8'h81, 1'b0);
        drive_cycle(1'b1, 8'h5A, 1'b0);
        drive_cycle(1'b1, 8'hE7, 1'b0);
        check("sim_pre_count", 32'(fifo_count), 32'd3);
        repeat (5) drive_cycle(1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 8'h96, 1'b0);
        check("sim_count_kept", 32'(fifo_count), 32'd3);
        check("sim_pop_valid",  32'(di_valid),   32'd1);
        check("sim_pop_msb",    32'(di),         32'd1);
        for (int c = 0; c < 34; c++) drive_cycle(1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-frame with two frames queued
        drive_cycle(1'b1, 8'hA5, 1'b0);
        drive_cycle(1'b1, 8'h3C, 1'b0);
        drive_cycle(1'b1, 8'hF0, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        check("ar_pre_count", 32'(fifo_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_di",         32'(di),         32'd0);
        check("ar_di_valid",   32'(di_valid),   32'd0);
        check("ar_frame_done", 32'(frame_done), 32'd0);
        check("ar_fifo_count", 32'(fifo_count), 32'd0);
        check("ar_in_ready",   32'(in_ready),   32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        stale = 0;
        for (int c = 0; c < 20; c++) begin
            drive_cycle(1'b0, 8'h00, 1'b0);
            if (di_valid) stale++;
        end
        check("ar_no_stale_bits", 32'(stale), 32'd0);
        drive_cycle(1'b1, 8'h69, 1'b0);
        for (int c = 0; c < 10; c++) drive_cycle(1'b0, 8'h00, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 400; c++)
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                        ($urandom_range(0, 3) == 0));
        for (int c = 0; c < 40; c++) drive_cycle(1'b0, 8'h00, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ball_serializer.md
BALL_SERIALIZER -- requirements
Module: ball_serializer

Interface
REQ-001 SHALL have parameter FRAME_W, default 8, meaning balls per frame (one bit per ball).
REQ-002 SHALL have parameter DEPTH, default 4, meaning frame FIFO depth (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  in  FRAME_W  ball frame; bit FRAME_W-1 = first ball; 1 = red, 0 = blue.
REQ-006 SHALL have port in_valid  in  1  in_data holds a frame.
REQ-007 SHALL have port in_ready  out  1  block can accept a frame this cycle.
REQ-008 SHALL have port pause  in  1  downstream hold; no ball bit is issued on edges where pause=1.
REQ-009 SHALL have port di  out  1  serial ball bit to the sequence detector's di input.
REQ-010 SHALL have port di_valid  out  1  di carries a ball bit this cycle.
REQ-011 SHALL have port frame_done  out  1  one-cycle pulse aligned with the last bit of a frame.
REQ-012 SHALL have port fifo_count  out  $clog2(DEPTH)+1  frames currently queued (excludes the frame being shifted).

Function
REQ-013 SHALL push in_data into the FIFO on any edge where in_valid=1 and in_ready=1.
REQ-014 SHALL drive in_ready = (fifo_count < DEPTH) and not rst, combinationally from registered count.
REQ-015 SHALL implement states IDLE (no frame loaded) and SHIFT (frame loaded, bits remaining).
REQ-016 SHALL, on an edge with pause=0 in SHIFT, issue the next remaining bit of the current frame, MSB first.
REQ-017 SHALL, on an edge with pause=0 where no bits remain (IDLE, or SHIFT after issuing bit 0) and fifo_count>0, pop the FIFO head and issue its bit FRAME_W-1 on that same edge; next state SHIFT.
REQ-018 SHALL go to IDLE on the edge issuing bit 0 when the FIFO is empty.
REQ-019 SHALL register outputs: on an issuing edge di<=issued bit, di_valid<=1; otherwise di<=0, di_valid<=0.
REQ-020 SHALL set frame_done<=1 only on the edge issuing bit 0 of a frame, else 0.
REQ-021 SHALL deliver back-to-back frames with no gap cycle (FRAME_W bits in FRAME_W consecutive unpaused cycles).
REQ-022 SHALL give latency of exactly 1 edge: frame pushed at edge E into empty FIFO while IDLE and pause=0 -> bit FRAME_W-1 issued at edge E+1.
REQ-023 SHALL, when pause=1, hold state, bit position and FIFO read side; FIFO may still accept pushes.
REQ-024 SHALL, on simultaneous push and pop, leave fifo_count unchanged and store the pushed frame in order.
REQ-025 SHALL wrap FIFO read/write pointers modulo DEPTH; push is impossible when full (in_ready=0), so no overflow.

Reset
REQ-026 SHALL, while rst=1, force di=0, di_valid=0, frame_done=0, fifo_count=0, in_ready=0, state IDLE, pointers 0.
REQ-027 SHALL discard any queued or partially shifted frame when rst asserts mid-operation; no further bits of it issued after release.
REQ-028 SHALL, on the first edge after rst deasserts, behave as IDLE with an empty FIFO.

Structure
REQ-029 SHALL place FRAME_W/DEPTH defaults, colour encoding constants (RED=1, BLUE=0) and the IDLE/SHIFT state type in shared package ball_pkg.
REQ-030 SHALL implement the frame queue as sub-module ball_fifo (synchronous FIFO, count output), instantiated once; shifter FSM in the top.

Verification
REQ-031 SHALL cover: push 8'b1010_1100 after reset, pause=0 -> di sequence 1,0,1,0,1,1,0,0 on 8 consecutive cycles, di_valid=1 throughout, frame_done only with final 0.
REQ-032 SHALL cover: push 8'hFF then 8'h00 consecutively -> 16 contiguous di_valid cycles, eight 1s then eight 0s, frame_done twice, 8 cycles apart.
REQ-033 SHALL cover: hold in_valid=1 with pause=1 -> after 4 pushes fifo_count=4, in_ready=0, di_valid=0; release pause -> in_ready returns 1 on the first pop.
REQ-034 SHALL cover: pause=1 for 3 cycles after 3rd bit of 8'b1100_1010 -> di_valid=0 for 3 cycles, then bits 0,1,0,1,0 resume in order.
REQ-035 SHALL cover: assert rst asynchronously mid-frame with 2 frames queued -> di/di_valid/fifo_count go 0 immediately; after release no bits appear until a new push.
REQ-036 SHALL cover: push at count=3 on the same edge as a pop -> fifo_count stays 3 and frames emerge in push order.
